// File: rtl/imem_loader.sv
// Program loader and backing store for the instruction memory: streams bytes in over
// valid/ready, zero-pads to a word boundary, and serves big-endian fetch words combinationally.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 512,
    parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_load_len,
    input  logic [7:0]        i_byte_in,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic [31:0]       o_fetch_data,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_load_done,
    output logic [ADDR_W:0]   o_wr_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LEN_MAX = CNT_W'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(MEM_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_mem [MEM_BYTES];
    logic [CNT_W-1:0]    r_len;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]    r_wr_count;
    logic                r_byte_ready;
    logic                r_cpu_hold;
    logic                r_busy;
    logic                r_load_done;

    logic [CNT_W-1:0]    w_len;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_start_ok;
    logic                w_wr_en;
    logic [7:0]          w_wr_data;
    logic [ADDR_W-1:0]   w_fa0;
    logic [ADDR_W-1:0]   w_fa1;
    logic [ADDR_W-1:0]   w_fa2;
    logic [ADDR_W-1:0]   w_fa3;

    assign w_len     = (i_load_len > LEN_MAX) ? LEN_MAX : i_load_len;
    assign w_cnt_inc = r_wr_count + CNT_W'(1);

    // Next-state and write-port control
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_data   = i_byte_in;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = (w_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (i_byte_valid) begin
                    w_wr_en = 1'b1;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt = (w_cnt_inc[1:0] == 2'b00) ? ST_DONE : ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                w_wr_en   = 1'b1;
                w_wr_data = 8'h00;
                // Zero bytes make a partial trailing instruction decode as NOP
                if ((w_cnt_inc[1:0] == 2'b00) || (r_wr_ptr == PTR_MAX)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pointers and registered status outputs decoded from the next state
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_wr_ptr     <= '0;
            r_wr_count   <= '0;
            r_byte_ready <= 1'b0;
            r_cpu_hold   <= 1'b0;
            r_busy       <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte_ready <= (w_state_nxt == ST_LOAD);
            r_cpu_hold   <= (w_state_nxt != ST_IDLE);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_load_done  <= (w_state_nxt == ST_DONE);
            if (w_start_ok) begin
                r_len      <= w_len;
                r_wr_ptr   <= '0;
                r_wr_count <= '0;
            end else if (w_wr_en) begin
                r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
                r_wr_count <= w_cnt_inc;
            end
        end
    end

    // Storage survives reset so a loaded program is kept across CPU resets
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    assign w_fa0 = i_fetch_addr;
    assign w_fa1 = i_fetch_addr + ADDR_W'(1);
    assign w_fa2 = i_fetch_addr + ADDR_W'(2);
    assign w_fa3 = i_fetch_addr + ADDR_W'(3);

    assign o_fetch_data = {r_mem[w_fa0], r_mem[w_fa1], r_mem[w_fa2], r_mem[w_fa3]};
    assign o_byte_ready = r_byte_ready;
    assign o_cpu_hold   = r_cpu_hold;
    assign o_busy       = r_busy;
    assign o_load_done  = r_load_done;
    assign o_wr_count   = r_wr_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: aligned/padded loads, backpressure,
// reset mid-load, ignored/zero-length starts, full-depth load with fetch wrap and clamp.
module tb_imem_loader;

    localparam int unsigned ADDR_W = 9;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_start;
    logic [ADDR_W:0]   i_load_len;
    logic [7:0]        i_byte_in;
    logic              i_byte_valid;
    logic              o_byte_ready;
    logic [ADDR_W-1:0] i_fetch_addr;
    logic [31:0]       o_fetch_data;
    logic              o_cpu_hold;
    logic              o_busy;
    logic              o_load_done;
    logic [ADDR_W:0]   o_wr_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] tb_data [1024];

    imem_loader dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_load_len   (i_load_len),
        .i_byte_in    (i_byte_in),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .i_fetch_addr (i_fetch_addr),
        .o_fetch_data (o_fetch_data),
        .o_cpu_hold   (o_cpu_hold),
        .o_busy       (o_busy),
        .o_load_done  (o_load_done),
        .o_wr_count   (o_wr_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_fetch(input string tag, input int addr, input logic [31:0] exp);
        i_fetch_addr = ADDR_W'(addr);
        #1;
        check(tag, o_fetch_data, exp);
    endtask

    // Issue start, stream tb_data[0..n-1], stop when load_done is seen or budget expires
    task automatic do_load(input int len_in, input int n, input bit toggle,
                           output int cyc, output int rdy, output bit hold_drop);
        int  i;
        bit  acc;
        i = 0; cyc = 0; rdy = 0; hold_drop = 1'b0;
        i_start    = 1'b1;
        i_load_len = (ADDR_W+1)'(len_in);
        tick();
        i_start = 1'b0;
        while (o_load_done !== 1'b1 && cyc < 3000) begin
            i_byte_valid = (i < n) && (!toggle || (cyc % 3 == 0));
            i_byte_in    = i_byte_valid ? tb_data[i] : 8'(cyc * 7);
            if (o_byte_ready) rdy++;
            if (!o_cpu_hold) hold_drop = 1'b1;
            acc = o_byte_ready && i_byte_valid;
            tick();
            if (acc) i++;
            cyc++;
        end
        i_byte_valid = 1'b0;
    endtask

    int cyc, rdy;
    bit hold_drop;

    initial begin
        i_reset = 1'b1; i_start = 1'b1; i_load_len = 10'd8;
        i_byte_in = 8'h00; i_byte_valid = 1'b0; i_fetch_addr = '0;
        tick(); tick();
        check("rst_busy", o_busy, 1'b0);
        check("rst_ready", o_byte_ready, 1'b0);
        check("rst_hold", o_cpu_hold, 1'b0);
        check("rst_done", o_load_done, 1'b0);
        check("rst_wr_count", o_wr_count, 10'd0);
        i_start = 1'b0;
        i_reset = 1'b0;
        tick();

        // 8-byte aligned load, valid held high
        tb_data[0] = 8'h24; tb_data[1] = 8'h08; tb_data[2] = 8'h00; tb_data[3] = 8'h05;
        tb_data[4] = 8'h00; tb_data[5] = 8'h00; tb_data[6] = 8'h00; tb_data[7] = 8'h00;
        do_load(8, 8, 1'b0, cyc, rdy, hold_drop);
        check("A_done", o_load_done, 1'b1);
        check("A_cycles", 32'(cyc), 32'd8);
        check("A_ready_cycles", 32'(rdy), 32'd8);
        check("A_done_ready", o_byte_ready, 1'b0);
        check("A_done_hold", o_cpu_hold, 1'b1);
        check("A_wr_count", o_wr_count, 10'd8);
        tick();
        check("A_done_pulse", o_load_done, 1'b0);
        check("A_hold_drop", o_cpu_hold, 1'b0);
        check("A_busy_drop", o_busy, 1'b0);
        check_fetch("A_fetch0", 0, 32'h24080005);
        check_fetch("A_fetch4", 4, 32'h00000000);

        // 6-byte load padded with two zeros
        tb_data[0] = 8'hAA; tb_data[1] = 8'hBB; tb_data[2] = 8'hCC; tb_data[3] = 8'hDD;
        tb_data[4] = 8'h11; tb_data[5] = 8'h22; tb_data[6] = 8'h77; tb_data[7] = 8'h88;
        do_load(6, 6, 1'b0, cyc, rdy, hold_drop);
        check("B_done", o_load_done, 1'b1);
        check("B_cycles", 32'(cyc), 32'd8);
        check("B_ready_cycles", 32'(rdy), 32'd6);
        check("B_wr_count", o_wr_count, 10'd8);
        tick();
        check_fetch("B_fetch0", 0, 32'hAABBCCDD);
        check_fetch("B_fetch4", 4, 32'h11220000);

        // Same 8-byte stream under valid pattern 1,0,0
        tb_data[0] = 8'h24; tb_data[1] = 8'h08; tb_data[2] = 8'h00; tb_data[3] = 8'h05;
        tb_data[4] = 8'h00; tb_data[5] = 8'h00; tb_data[6] = 8'h00; tb_data[7] = 8'h00;
        do_load(8, 8, 1'b1, cyc, rdy, hold_drop);
        check("C_done", o_load_done, 1'b1);
        check("C_cycles", 32'(cyc), 32'd22);
        check("C_hold_kept", 32'(hold_drop), 32'd0);
        check("C_wr_count", o_wr_count, 10'd8);
        tick();
        check_fetch("C_fetch0", 0, 32'h24080005);
        check_fetch("C_fetch4", 4, 32'h00000000);

        // Reset after three bytes of an 8-byte load
        i_start = 1'b1; i_load_len = 10'd8;
        tick();
        i_start = 1'b0;
        i_byte_valid = 1'b1;
        i_byte_in = 8'hF1; tick();
        i_byte_in = 8'hF2; tick();
        i_byte_in = 8'hF3; tick();
        i_byte_valid = 1'b0;
        check("D_wr_count_pre", o_wr_count, 10'd3);
        #2;
        i_reset = 1'b1;
        #1;
        check("D_rst_busy", o_busy, 1'b0);
        check("D_rst_ready", o_byte_ready, 1'b0);
        check("D_rst_hold", o_cpu_hold, 1'b0);
        check("D_rst_wr_count", o_wr_count, 10'd0);
        tick();
        i_reset = 1'b0;
        tick();
        check("D_no_done0", o_load_done, 1'b0);
        tick();
        check("D_no_done1", o_load_done, 1'b0);
        check_fetch("D_fetch0", 0, 32'hF1F2F305);

        // start while busy is ignored; byte offered in DONE is not taken
        i_start = 1'b1; i_load_len = 10'd4;
        tick();
        i_load_len = 10'd0;
        i_byte_valid = 1'b1; i_byte_in = 8'h01;
        tick();
        i_start = 1'b0;
        check("E_busy", o_busy, 1'b1);
        check("E_ready", o_byte_ready, 1'b1);
        check("E_wr_count1", o_wr_count, 10'd1);
        i_byte_in = 8'h02; tick();
        i_byte_in = 8'h03; tick();
        i_byte_in = 8'h04; tick();
        check("E_done", o_load_done, 1'b1);
        check("E_done_ready", o_byte_ready, 1'b0);
        i_byte_in = 8'hEE;
        tick();
        i_byte_valid = 1'b0;
        check("E_done_pulse", o_load_done, 1'b0);
        check("E_wr_count", o_wr_count, 10'd4);
        check_fetch("E_fetch0", 0, 32'h01020304);
        check_fetch("E_fetch4", 4, 32'h00000000);

        // Zero-length load: one DONE cycle, no writes
        i_start = 1'b1; i_load_len = 10'd0;
        tick();
        i_start = 1'b0;
        check("Z_done", o_load_done, 1'b1);
        check("Z_busy", o_busy, 1'b1);
        check("Z_ready", o_byte_ready, 1'b0);
        check("Z_wr_count", o_wr_count, 10'd0);
        tick();
        check("Z_done_pulse", o_load_done, 1'b0);
        check("Z_idle", o_busy, 1'b0);
        check_fetch("Z_fetch0", 0, 32'h01020304);

        // Full-depth load, fetch wrap-around
        for (int k = 0; k < 1024; k++) tb_data[k] = 8'(k);
        do_load(512, 512, 1'b0, cyc, rdy, hold_drop);
        check("F_done", o_load_done, 1'b1);
        check("F_cycles", 32'(cyc), 32'd512);
        check("F_wr_count", o_wr_count, 10'd512);
        tick();
        check_fetch("F_fetch510", 510, 32'hFEFF0001);
        check_fetch("F_fetch511", 511, 32'hFF000102);
        check_fetch("F_fetch100", 100, 32'h64656667);

        // load_len above depth clamps to 512
        for (int k = 0; k < 1024; k++) tb_data[k] = 8'(k) ^ 8'h5A;
        do_load(600, 600, 1'b0, cyc, rdy, hold_drop);
        check("G_done", o_load_done, 1'b1);
        check("G_cycles", 32'(cyc), 32'd512);
        check("G_wr_count", o_wr_count, 10'd512);
        tick();
        check("G_idle", o_busy, 1'b0);
        check_fetch("G_fetch0", 0, 32'h5A5B5859);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader and backing store for the 512×8 instruction memory. Accepts a byte stream over a valid/ready handshake, writes it sequentially from address 0, zero-pads to a word boundary, and holds the pipeline while loading. The fetch stage reads a big-endian 32-bit word from the same storage through a combinational port. It replaces file-based precharge as the write side of the fetch path.

## Interface
- MEM_BYTES, 512: storage depth in bytes; a power of two.
- ADDR_W, 9: byte address width, log2(MEM_BYTES).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  load request; sampled only in IDLE.
- load_len  in  ADDR_W+1  byte count; sampled with start.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- fetch_addr  in  ADDR_W  fetch byte address, normally PC[8:0].
- fetch_data  out  32  {mem[a], mem[a+1], mem[a+2], mem[a+3]}, with addresses taken mod MEM_BYTES.
- cpu_hold  out  1  stalls PC/NPC and pipeline registers.
- busy  out  1  FSM is not in IDLE.
- load_done  out  1  one-cycle pulse when a load completes.
- wr_count  out  ADDR_W+1  bytes written so far in the current or last load, including padding.

## Operation
- States: IDLE, LOAD, PAD, DONE.
- IDLE:
  - On start=1, latch len = min(load_len, MEM_BYTES), clear wr_ptr and wr_count.
  - If len=0, go to DONE; otherwise go to LOAD.
  - A start in any other state is ignored.
- LOAD:
  - byte_ready=1.
  - On each edge with byte_valid&&byte_ready: mem[wr_ptr] <= byte_in, wr_ptr++, wr_count++.
  - When the accepted byte is byte number len: go to DONE if (wr_count+1) is a multiple of 4, else go to PAD.
- PAD:
  - byte_ready=0.
  - Write 8'h00 to mem[wr_ptr] each cycle, incrementing wr_ptr and wr_count, until wr_count is a multiple of 4; then go to DONE.
  - The zero padding makes any partial trailing instruction decode as NOP.
  - If wr_ptr wraps past MEM_BYTES-1 (len=MEM_BYTES is always aligned, so padding never wraps), stop and go to DONE.
- DONE: load_done=1 for exactly one cycle, then go to IDLE.
- cpu_hold = 1 in LOAD, PAD and DONE; 0 in IDLE. busy follows the same rule.
- Fetch reads are combinational, ignore the FSM, and return the current storage contents. The address sum wraps mod MEM_BYTES, so fetch_addr=511 returns {mem[511], mem[0], mem[1], mem[2]}.
- Storage is not cleared by reset. Bytes written before a reset remain.

## Timing
- Reset values:
  - State IDLE.
  - byte_ready=0, cpu_hold=0, busy=0, load_done=0.
  - wr_count=0; internal wr_ptr=0.
  - fetch_data reflects storage and is unaffected by reset.
- start high at edge t0 (in IDLE): LOAD from t0+. byte_ready=1 in the cycle after t0.
- Each accepted byte is written on its edge and visible on fetch_data immediately after that edge. Throughput is 1 byte per cycle.
- Backpressure: byte_valid low for any number of cycles stalls LOAD without a timeout. byte_in is don't-care while byte_valid=0.
- Last byte accepted at edge tk:
  - Aligned: DONE during cycle tk..tk+1, load_done high there, IDLE and cpu_hold=0 from tk+1.
  - Unaligned with p pad bytes (1–3): PAD for p cycles, then DONE, with load_done in cycle tk+p..tk+p+1.
- byte_ready is 0 in the DONE cycle, so a byte offered there is not taken.
- Asynchronous reset mid-load: FSM goes to IDLE at once and all outputs take their reset values. The partial load is not padded and no load_done is generated.
- start and reset high together: reset wins.

## Test plan
- Load of 8 bytes 8'h24,08,00,05,00,00,00,00 with byte_valid held high:
  - byte_ready=1 for 8 cycles.
  - fetch_addr=0 reads 32'h24080005; fetch_addr=4 reads 32'h00000000.
  - load_done pulses once; wr_count=8; cpu_hold drops the cycle after DONE.
- Load of 6 bytes AA,BB,CC,DD,11,22:
  - 2 PAD cycles write zeros.
  - fetch_addr=4 reads 32'h11220000; wr_count=8.
- Same 8-byte stream with byte_valid toggled 1,0,0,1,…: contents are identical, load_done is delayed by the idle cycles, and cpu_hold stays 1 throughout.
- Reset pulsed after 3 bytes:
  - Outputs return to reset values immediately; no load_done.
  - fetch_addr=0 returns the first three bytes followed by prior mem[3].
- start while busy, and start with load_len=0:
  - The first is ignored.
  - The second gives one DONE cycle, load_done=1, wr_count=0, and no writes.
- Load of 512 bytes with value = address[7:0]:
  - load_done with no PAD.
  - fetch_addr=510 reads 32'hFEFF0001 (wrap-around).
  - A later load_len=600 clamps to 512.
